vec_column_assembler: RTL and testbench

//   Consumer end of the EX-stage column-write interface of the SIMD AES pipeline.

---
 rtl/vec_column_assembler.sv | 107 ++++++++++
 tb/tb_vec_column_assembler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_column_assembler.sv
// Purpose: gathers NCOL column words for one destination register into a single vector write.
// Latency: vector is presented the cycle after the accept that fills the last column.
// Backpressure: in_ready drops while a finished vector waits for out_ready; flush overrides everything.
module vec_column_assembler #(
    parameter int DATA_W  = 32,
    parameter int NCOL    = 4,
    parameter int RADDR_W = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_colwrite,
    input  logic [$clog2(NCOL)-1:0]   in_columna,
    input  logic [RADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_flush,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [RADDR_W-1:0]        out_rd,
    output logic [NCOL*DATA_W-1:0]    out_vdata,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      err_rd_mismatch
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [NCOL-1:0]          mask, mask_nxt;
    logic [RADDR_W-1:0]       rd_q, rd_nxt;
    logic [NCOL*DATA_W-1:0]   vdata_q, vdata_nxt;
    logic                     err_q, err_nxt;
    logic [NCOL-1:0]          col_bit;
    logic                     accept;

    assign in_ready        = (state != HOLD);
    assign accept          = in_valid & in_colwrite & in_ready;
    assign busy            = (state == COLLECT);
    assign out_valid       = (state == HOLD);
    assign out_rd          = rd_q;
    assign out_vdata       = vdata_q;
    assign err_rd_mismatch = err_q;

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        rd_nxt    = rd_q;
        vdata_nxt = vdata_q;
        err_nxt   = 1'b0;
        col_bit   = '0;
        col_bit[in_columna] = 1'b1;

        if (in_flush) begin
            state_nxt = IDLE;
            mask_nxt  = '0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        // A new vector (or a register change mid-vector) starts from clean columns.
                        if (state == IDLE || in_rd != rd_q) begin
                            err_nxt   = (state == COLLECT);
                            vdata_nxt = '0;
                            mask_nxt  = col_bit;
                            rd_nxt    = in_rd;
                        end else begin
                            mask_nxt  = mask | col_bit;
                        end
                        vdata_nxt[in_columna*DATA_W +: DATA_W] = in_data;
                        state_nxt = (mask_nxt == '1) ? HOLD : COLLECT;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                        mask_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    mask_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask    <= '0;
            rd_q    <= '0;
            vdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mask    <= mask_nxt;
            rd_q    <= rd_nxt;
            vdata_q <= vdata_nxt;
            err_q   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vec_column_assembler.sv
// Scoreboarded bench for vec_column_assembler: expected vectors are queued as stimulus completes them.
module tb_vec_column_assembler;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_colwrite;
    logic [1:0]   in_columna;
    logic [4:0]   in_rd;
    logic [31:0]  in_data;
    logic         in_flush;
    logic         in_ready;
    logic         out_valid;
    logic [4:0]   out_rd;
    logic [127:0] out_vdata;
    logic         out_ready;
    logic         busy;
    logic         err_rd_mismatch;

    typedef struct packed {
        logic [4:0]   rd;
        logic [127:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vec_column_assembler #(.DATA_W(32), .NCOL(4), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_colwrite(in_colwrite), .in_columna(in_columna),
        .in_rd(in_rd), .in_data(in_data), .in_flush(in_flush), .in_ready(in_ready),
        .out_valid(out_valid), .out_rd(out_rd), .out_vdata(out_vdata),
        .out_ready(out_ready), .busy(busy), .err_rd_mismatch(err_rd_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every handshake must match the oldest expected vector.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !in_flush) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got rd=%0d vdata=%h, required no vector", out_rd, out_vdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_rd !== e.rd || out_vdata !== e.v) begin
                    errors++;
                    $display("FAIL sb_vector: got rd=%0d vdata=%h, required rd=%0d vdata=%h",
                             out_rd, out_vdata, e.rd, e.v);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_colwrite = 1'b0;
        in_columna  = 2'd0;
        in_rd       = 5'd0;
        in_data     = 32'd0;
        in_flush    = 1'b0;
    endtask

    task automatic send_col(input logic [1:0] c, input logic [4:0] rd, input logic [31:0] d);
        in_valid    = 1'b1;
        in_colwrite = 1'b1;
        in_columna  = c;
        in_rd       = rd;
        in_data     = d;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        exp_t e;
        idle_inputs();
        out_ready = 1'b1;
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err_rd_mismatch !== 1'b0 ||
            out_rd !== 5'd0 || out_vdata !== 128'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b busy=%b err=%b rd=%0d vd=%h rdy=%b, required 0 0 0 0 0 1",
                     out_valid, busy, err_rd_mismatch, out_rd, out_vdata, in_ready);
        end
        rst_n = 1'b1;
        tick();
        send_col(2'd0, 5'd2, 32'hDEAD0000);
        send_col(2'd1, 5'd2, 32'hDEAD0001);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_col(2'd1, 5'd2, 32'hB0000001);
        send_col(2'd2, 5'd2, 32'hB0000002);
        send_col(2'd3, 5'd2, 32'hB0000003);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fresh: got out_valid=%b, required 0 (old columns must be gone)", out_valid);
        end
        e.rd = 5'd2;
        e.v  = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
        sb.push_back(e);
        send_col(2'd0, 5'd2, 32'hB0000000);
        tick();
    endtask

    task automatic test_in_order();
        exp_t e;
        out_ready = 1'b0;
        send_col(2'd0, 5'd7, 32'h11111111);
        send_col(2'd1, 5'd7, 32'h22222222);
        send_col(2'd2, 5'd7, 32'h33333333);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inorder_early: got out_valid=%b, required 0", out_valid);
        end
        e.rd = 5'd7;
        e.v  = 128'h44444444_33333333_22222222_11111111;
        sb.push_back(e);
        send_col(2'd3, 5'd7, 32'h44444444);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL inorder_latency: got out_valid=%b busy=%b, required 1 0", out_valid, busy);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL inorder_release: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_out_of_order_dup();
        exp_t e;
        out_ready = 1'b0;
        send_col(2'd2, 5'd3, 32'hC2C2C2C2);
        send_col(2'd0, 5'd3, 32'hC0C0C0C0);
        send_col(2'd2, 5'd3, 32'h000000AA);
        send_col(2'd3, 5'd3, 32'hC3C3C3C3);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ooo_dup_early: got out_valid=%b busy=%b, required 0 1", out_valid, busy);
        end
        e.rd = 5'd3;
        e.v  = {32'hC3C3C3C3, 32'h000000AA, 32'hC1C1C1C1, 32'hC0C0C0C0};
        sb.push_back(e);
        send_col(2'd1, 5'd3, 32'hC1C1C1C1);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ooo_dup_done: got out_valid=%b, required 1", out_valid);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        e.rd = 5'd12;
        e.v  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        sb.push_back(e);
        send_col(2'd3, 5'd12, 32'hD3);
        send_col(2'd1, 5'd12, 32'hD1);
        send_col(2'd0, 5'd12, 32'hD0);
        send_col(2'd2, 5'd12, 32'hD2);
        in_valid    = 1'b1;
        in_colwrite = 1'b1;
        in_columna  = 2'd0;
        in_rd       = 5'd12;
        in_data     = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_rd !== e.rd || out_vdata !== e.v) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b rd=%0d vd=%h, required 0 1 %0d %h",
                         i, in_ready, out_valid, out_rd, out_vdata, e.rd, e.v);
            end
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b, required 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_rd_mismatch();
        exp_t e;
        out_ready = 1'b1;
        send_col(2'd0, 5'd4, 32'hEEEE0004);
        checks++;
        if (err_rd_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mm_no_err_first: got %b, required 0", err_rd_mismatch);
        end
        send_col(2'd1, 5'd9, 32'h99990001);
        checks++;
        if (err_rd_mismatch !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mm_pulse: got err=%b busy=%b, required 1 1", err_rd_mismatch, busy);
        end
        tick();
        checks++;
        if (err_rd_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mm_pulse_width: got %b, required 0", err_rd_mismatch);
        end
        send_col(2'd0, 5'd9, 32'h99990000);
        send_col(2'd2, 5'd9, 32'h99990002);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mm_partial: got out_valid=%b, required 0", out_valid);
        end
        e.rd = 5'd9;
        e.v  = {32'h99990003, 32'h99990002, 32'h99990001, 32'h99990000};
        sb.push_back(e);
        send_col(2'd3, 5'd9, 32'h99990003);
        checks++;
        if (out_valid !== 1'b1 || out_rd !== 5'd9) begin
            errors++;
            $display("FAIL mm_complete: got v=%b rd=%0d, required 1 9", out_valid, out_rd);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_col(2'd0, 5'd5, 32'hF0);
        in_flush = 1'b1;
        send_col(2'd1, 5'd5, 32'hF1);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err_rd_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL flush_collect: got busy=%b v=%b err=%b, required 0 0 0", busy, out_valid, err_rd_mismatch);
        end
        send_col(2'd1, 5'd5, 32'hF1);
        send_col(2'd2, 5'd5, 32'hF2);
        send_col(2'd3, 5'd5, 32'hF3);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_cleared_mask: got v=%b busy=%b, required 0 1", out_valid, busy);
        end
        in_flush = 1'b1;
        tick();
        idle_inputs();
        out_ready = 1'b0;
        send_col(2'd0, 5'd6, 32'h60);
        send_col(2'd1, 5'd6, 32'h61);
        send_col(2'd2, 5'd6, 32'h62);
        send_col(2'd3, 5'd6, 32'h63);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold_setup: got out_valid=%b, required 1", out_valid);
        end
        in_flush = 1'b1;
        send_col(2'd0, 5'd6, 32'h70);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || err_rd_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: got v=%b busy=%b rdy=%b err=%b, required 0 0 1 0",
                     out_valid, busy, in_ready, err_rd_mismatch);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_vector: got v=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_out_of_order_dup();
        test_backpressure();
        test_rd_mismatch();
        test_flush();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d vectors outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
